// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - encodings, control word type and timing states for the control unit
package cu_pkg;

    // Timing states; T is the only state the control unit holds.
    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3
    } t_state;

    localparam logic [5:0] OP_BRA = 6'h00;
    localparam logic [5:0] OP_BNE = 6'h01;
    localparam logic [5:0] OP_INC = 6'h02;
    localparam logic [5:0] OP_MOV = 6'h03;
    localparam logic [5:0] OP_ADD = 6'h04;
    localparam logic [5:0] OP_LDI = 6'h05;
    localparam logic [5:0] OP_LD  = 6'h06;
    localparam logic [5:0] OP_ST  = 6'h07;

    localparam logic [2:0] RF_DEC  = 3'b000;
    localparam logic [2:0] RF_INC  = 3'b001;
    localparam logic [2:0] RF_LOAD = 3'b010;
    localparam logic [2:0] RF_CLR  = 3'b011;

    localparam logic [1:0] ARF_DEC  = 2'b00;
    localparam logic [1:0] ARF_INC  = 2'b01;
    localparam logic [1:0] ARF_LOAD = 2'b10;
    localparam logic [1:0] ARF_CLR  = 2'b11;

    localparam logic [2:0] ARF_SEL_PC = 3'b100;
    localparam logic [2:0] ARF_SEL_AR = 3'b010;
    localparam logic [2:0] ARF_SEL_SP = 3'b001;

    localparam logic [1:0] OUTD_PC = 2'b00;
    localparam logic [1:0] OUTD_AR = 2'b10;
    localparam logic [1:0] OUTD_SP = 2'b11;

    localparam logic [1:0] MUX_ALUOUT  = 2'b00;
    localparam logic [1:0] MUX_ARFOUTC = 2'b01;
    localparam logic [1:0] MUX_DROUT   = 2'b10;
    localparam logic [1:0] MUX_IROUT   = 2'b11;

    localparam logic [4:0] ALU_PASSA = 5'b10000;
    localparam logic [4:0] ALU_ADD   = 5'b10100;

    localparam logic [1:0] DR_LOAD_LOW = 2'b01;

    // Everything the datapath needs for one cycle.
    typedef struct packed {
        logic [1:0] MuxASel;
        logic [1:0] MuxBSel;
        logic [1:0] MuxCSel;
        logic       MuxDSel;
        logic [3:0] RFRegSel;
        logic [3:0] RFScrSel;
        logic [2:0] RFFunSel;
        logic [2:0] RFOutASel;
        logic [2:0] RFOutBSel;
        logic [4:0] ALUFunSel;
        logic [2:0] ARFRegSel;
        logic [1:0] ARFFunSel;
        logic [1:0] ARFOutCSel;
        logic [1:0] ARFOutDSel;
        logic       DREnable;
        logic [1:0] DRFunSel;
        logic       MemCS;
        logic       MemWR;
        logic       IRHighSel;
        logic       IRWrite;
    } ctrl_word_t;

    // No register enabled, memory deselected: safe to hold forever.
    function automatic ctrl_word_t idle_word();
        ctrl_word_t w;
        w       = '0;
        w.MemCS = 1'b1;
        return w;
    endfunction

    // Register index 0..3 selects R1..R4, R1 being the MSB enable.
    function automatic logic [3:0] rf_onehot(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control unit to datapath connection
interface control_unit_if;
    logic [15:0] IRIn;
    logic [3:0]  Flags;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic [1:0]  MuxCSel;
    logic        MuxDSel;
    logic [3:0]  RFRegSel;
    logic [3:0]  RFScrSel;
    logic [2:0]  RFFunSel;
    logic [2:0]  RFOutASel;
    logic [2:0]  RFOutBSel;
    logic [4:0]  ALUFunSel;
    logic [2:0]  ARFRegSel;
    logic [1:0]  ARFFunSel;
    logic [1:0]  ARFOutCSel;
    logic [1:0]  ARFOutDSel;
    logic        DREnable;
    logic [1:0]  DRFunSel;
    logic        MemCS;
    logic        MemWR;
    logic        IRHighSel;
    logic        IRWrite;

    modport master (
        input  IRIn, Flags,
        output MuxASel, MuxBSel, MuxCSel, MuxDSel,
        output RFRegSel, RFScrSel, RFFunSel, RFOutASel, RFOutBSel,
        output ALUFunSel,
        output ARFRegSel, ARFFunSel, ARFOutCSel, ARFOutDSel,
        output DREnable, DRFunSel, MemCS, MemWR, IRHighSel, IRWrite
    );

    modport slave (
        output IRIn, Flags,
        input  MuxASel, MuxBSel, MuxCSel, MuxDSel,
        input  RFRegSel, RFScrSel, RFFunSel, RFOutASel, RFOutBSel,
        input  ALUFunSel,
        input  ARFRegSel, ARFFunSel, ARFOutCSel, ARFOutDSel,
        input  DREnable, DRFunSel, MemCS, MemWR, IRHighSel, IRWrite
    );
endinterface

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational map from timing state, IR and Z flag to the control word
module cu_decoder
    import cu_pkg::*;
(
    input  t_state     t,
    input  logic [15:0] ir,
    input  logic        z,
    output ctrl_word_t  cw,
    output logic        last
);

    logic [5:0] opcode;
    logic [1:0] rx;
    logic [2:0] dst;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       rr_bad;
    logic       rrr_bad;

    assign opcode  = ir[15:10];
    assign rx      = ir[9:8];
    assign dst     = ir[8:6];
    assign s1      = ir[5:3];
    assign s2      = ir[2:0];
    // Register fields above 3 name no register, so the instruction degrades to a NOP.
    assign rr_bad  = dst[2] | s1[2];
    assign rrr_bad = rr_bad | s2[2];

    // Control word and end-of-instruction flag for the current timing state.
    always_comb begin
        cw   = idle_word();
        last = 1'b1;
        case (t)
            T0, T1: begin
                cw.ARFOutDSel = OUTD_PC;
                cw.MemCS      = 1'b0;
                cw.MemWR      = 1'b0;
                cw.IRWrite    = 1'b1;
                cw.IRHighSel  = (t == T1);
                cw.ARFRegSel  = ARF_SEL_PC;
                cw.ARFFunSel  = ARF_INC;
                last          = 1'b0;
            end
            T2: begin
                case (opcode)
                    OP_BRA, OP_BNE: begin
                        if (opcode == OP_BRA || !z) begin
                            cw.MuxBSel   = MUX_IROUT;
                            cw.ARFRegSel = ARF_SEL_PC;
                            cw.ARFFunSel = ARF_LOAD;
                        end
                    end
                    OP_INC, OP_MOV: begin
                        if (!rr_bad) begin
                            cw.RFOutASel = s1;
                            cw.MuxDSel   = 1'b0;
                            cw.ALUFunSel = ALU_PASSA;
                            cw.MuxASel   = MUX_ALUOUT;
                            cw.RFRegSel  = rf_onehot(dst[1:0]);
                            cw.RFFunSel  = RF_LOAD;
                            last         = (opcode != OP_INC);
                        end
                    end
                    OP_ADD: begin
                        if (!rrr_bad) begin
                            cw.RFOutASel = s1;
                            cw.RFOutBSel = s2;
                            cw.MuxDSel   = 1'b0;
                            cw.ALUFunSel = ALU_ADD;
                            cw.MuxASel   = MUX_ALUOUT;
                            cw.RFRegSel  = rf_onehot(dst[1:0]);
                            cw.RFFunSel  = RF_LOAD;
                        end
                    end
                    OP_LDI: begin
                        cw.MuxASel  = MUX_IROUT;
                        cw.RFRegSel = rf_onehot(rx);
                        cw.RFFunSel = RF_LOAD;
                    end
                    OP_LD: begin
                        cw.ARFOutDSel = OUTD_AR;
                        cw.MemCS      = 1'b0;
                        cw.MemWR      = 1'b0;
                        cw.DREnable   = 1'b1;
                        cw.DRFunSel   = DR_LOAD_LOW;
                        last          = 1'b0;
                    end
                    OP_ST: begin
                        cw.RFOutASel  = {1'b0, rx};
                        cw.ALUFunSel  = ALU_PASSA;
                        cw.MuxCSel    = MUX_ALUOUT;
                        cw.ARFOutDSel = OUTD_AR;
                        cw.MemCS      = 1'b0;
                        cw.MemWR      = 1'b1;
                    end
                    default: ;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_INC: begin
                        if (!rr_bad) begin
                            cw.RFRegSel = rf_onehot(dst[1:0]);
                            cw.RFFunSel = RF_INC;
                        end
                    end
                    OP_LD: begin
                        cw.MuxASel  = MUX_DROUT;
                        cw.RFRegSel = rf_onehot(rx);
                        cw.RFFunSel = RF_LOAD;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired sequencer: timing counter, decoder and reset gating
module control_unit
    import cu_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    control_unit_if.master dp,
    output logic [2:0]    T
);

    t_state     state;
    t_state     next_state;
    ctrl_word_t dec_word;
    ctrl_word_t word;
    logic       last;
    logic       unused_flags;

    // Only Z steers sequencing; the other flags pass by untouched.
    assign unused_flags = ^dp.Flags[2:0];

    cu_decoder u_decoder (
        .t    (state),
        .ir   (dp.IRIn),
        .z    (dp.Flags[3]),
        .cw   (dec_word),
        .last (last)
    );

    // Timing state register; reset abandons any instruction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= T0;
        end else begin
            state <= next_state;
        end
    end

    // Advance one timing step, or return to fetch after the final execute cycle.
    always_comb begin
        next_state = T0;
        if (!last) begin
            case (state)
                T0:      next_state = T1;
                T1:      next_state = T2;
                T2:      next_state = T3;
                default: next_state = T0;
            endcase
        end
    end

    // Hold the datapath idle while reset is asserted so nothing half-executes.
    always_comb begin
        word = dec_word;
        if (reset) begin
            word = idle_word();
        end
    end

    assign T             = state;
    assign dp.MuxASel    = word.MuxASel;
    assign dp.MuxBSel    = word.MuxBSel;
    assign dp.MuxCSel    = word.MuxCSel;
    assign dp.MuxDSel    = word.MuxDSel;
    assign dp.RFRegSel   = word.RFRegSel;
    assign dp.RFScrSel   = word.RFScrSel;
    assign dp.RFFunSel   = word.RFFunSel;
    assign dp.RFOutASel  = word.RFOutASel;
    assign dp.RFOutBSel  = word.RFOutBSel;
    assign dp.ALUFunSel  = word.ALUFunSel;
    assign dp.ARFRegSel  = word.ARFRegSel;
    assign dp.ARFFunSel  = word.ARFFunSel;
    assign dp.ARFOutCSel = word.ARFOutCSel;
    assign dp.ARFOutDSel = word.ARFOutDSel;
    assign dp.DREnable   = word.DREnable;
    assign dp.DRFunSel   = word.DRFunSel;
    assign dp.MemCS      = word.MemCS;
    assign dp.MemWR      = word.MemWR;
    assign dp.IRHighSel  = word.IRHighSel;
    assign dp.IRWrite    = word.IRWrite;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit against an instruction-level model
module tb_control_unit;

    typedef struct packed {
        logic [1:0] MuxASel;
        logic [1:0] MuxBSel;
        logic [1:0] MuxCSel;
        logic       MuxDSel;
        logic [3:0] RFRegSel;
        logic [3:0] RFScrSel;
        logic [2:0] RFFunSel;
        logic [2:0] RFOutASel;
        logic [2:0] RFOutBSel;
        logic [4:0] ALUFunSel;
        logic [2:0] ARFRegSel;
        logic [1:0] ARFFunSel;
        logic [1:0] ARFOutCSel;
        logic [1:0] ARFOutDSel;
        logic       DREnable;
        logic [1:0] DRFunSel;
        logic       MemCS;
        logic       MemWR;
        logic       IRHighSel;
        logic       IRWrite;
    } cw_t;

    logic       clock;
    logic       reset;
    logic [2:0] t_out;
    int         tests;
    int         fails;

    control_unit_if intf ();

    control_unit u_dut (
        .clock (clock),
        .reset (reset),
        .dp    (intf),
        .T     (t_out)
    );

    logic [44:0] dut_word;
    assign dut_word = {intf.MuxASel, intf.MuxBSel, intf.MuxCSel, intf.MuxDSel,
                       intf.RFRegSel, intf.RFScrSel, intf.RFFunSel, intf.RFOutASel, intf.RFOutBSel,
                       intf.ALUFunSel, intf.ARFRegSel, intf.ARFFunSel, intf.ARFOutCSel, intf.ARFOutDSel,
                       intf.DREnable, intf.DRFunSel, intf.MemCS, intf.MemWR, intf.IRHighSel, intf.IRWrite};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic cw_t idle_expect();
        cw_t w;
        w       = '0;
        w.MemCS = 1'b1;
        return w;
    endfunction

    // Register fields name R1..R4 as 0..3; anything larger turns the instruction into a NOP.
    function automatic bit fields_bad(input logic [15:0] ir);
        logic [5:0] op;
        op = ir[15:10];
        if (op == 6'd2 || op == 6'd3) return (ir[8:6] > 3'd3) || (ir[5:3] > 3'd3);
        if (op == 6'd4) return (ir[8:6] > 3'd3) || (ir[5:3] > 3'd3) || (ir[2:0] > 3'd3);
        return 1'b0;
    endfunction

    function automatic int exec_cycles(input logic [15:0] ir);
        logic [5:0] op;
        op = ir[15:10];
        if (op == 6'd6) return 2;
        if (op == 6'd2 && !fields_bad(ir)) return 2;
        return 1;
    endfunction

    // Expected control word for cycle 'step' (0 = first fetch) of the instruction 'ir'.
    function automatic cw_t model(input int step, input logic [15:0] ir, input logic [3:0] fl);
        cw_t        w;
        logic [5:0] op;
        logic [1:0] rx;
        logic [2:0] d;
        logic [2:0] a;
        logic [2:0] b;
        w  = idle_expect();
        op = ir[15:10];
        rx = ir[9:8];
        d  = ir[8:6];
        a  = ir[5:3];
        b  = ir[2:0];
        if (step < 2) begin
            w.MemCS     = 1'b0;
            w.IRWrite   = 1'b1;
            w.IRHighSel = (step == 1);
            w.ARFRegSel = 3'b100;
            w.ARFFunSel = 2'b01;
            return w;
        end
        if (op > 6'd7 || fields_bad(ir)) return w;
        if (op == 6'd0 || (op == 6'd1 && fl[3] == 1'b0)) begin
            w.MuxBSel   = 2'b11;
            w.ARFRegSel = 3'b100;
            w.ARFFunSel = 2'b10;
        end else if (op == 6'd2 && step == 3) begin
            w.RFRegSel = 4'b1000 >> d;
            w.RFFunSel = 3'b001;
        end else if (op == 6'd2 || op == 6'd3 || op == 6'd4) begin
            w.RFOutASel = a;
            w.RFOutBSel = (op == 6'd4) ? b : 3'b000;
            w.ALUFunSel = (op == 6'd4) ? 5'b10100 : 5'b10000;
            w.RFRegSel  = 4'b1000 >> d;
            w.RFFunSel  = 3'b010;
        end else if (op == 6'd5) begin
            w.MuxASel  = 2'b11;
            w.RFRegSel = 4'b1000 >> rx;
            w.RFFunSel = 3'b010;
        end else if (op == 6'd6 && step == 2) begin
            w.ARFOutDSel = 2'b10;
            w.MemCS      = 1'b0;
            w.DREnable   = 1'b1;
            w.DRFunSel   = 2'b01;
        end else if (op == 6'd6) begin
            w.MuxASel  = 2'b10;
            w.RFRegSel = 4'b1000 >> rx;
            w.RFFunSel = 3'b010;
        end else if (op == 6'd7) begin
            w.RFOutASel  = {1'b0, rx};
            w.ALUFunSel  = 5'b10000;
            w.ARFOutDSel = 2'b10;
            w.MemCS      = 1'b0;
            w.MemWR      = 1'b1;
        end
        return w;
    endfunction

    // Runs one instruction from T0; abort_at >= 0 pulses reset during that cycle instead of finishing.
    task automatic run_instr(input logic [15:0] ir, input logic [3:0] fl, input int abort_at);
        int  n;
        cw_t exp;
        n = 2 + exec_cycles(ir);
        for (int s = 0; s < n; s++) begin
            intf.IRIn  = (s < 2) ? 16'($urandom) : ir;
            intf.Flags = (s == 2) ? fl : 4'($urandom);
            if (s == abort_at) reset = 1'b1;
            #1;
            exp = (s == abort_at) ? idle_expect() : model(s, ir, fl);
            tests++;
            if (t_out !== 3'(s)) begin
                fails++;
                $display("FAIL timing ir=%h step %0d: T=%0d expected %0d", ir, s, t_out, s);
            end
            tests++;
            if (dut_word !== exp) begin
                fails++;
                $display("FAIL word ir=%h fl=%b step %0d: got %h expected %h", ir, fl, s, dut_word, exp);
            end
            @(negedge clock);
            if (s == abort_at) begin
                #1;
                tests++;
                if (t_out !== 3'd0 || dut_word !== idle_expect()) begin
                    fails++;
                    $display("FAIL reset_abort ir=%h: T=%0d word=%h expected T=0 word=%h", ir, t_out, dut_word, idle_expect());
                end
                reset = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        intf.IRIn  = 16'h0853;
        intf.Flags = 4'b0000;
        repeat (3) begin
            @(negedge clock);
            #1;
            tests++;
            if (t_out !== 3'd0 || dut_word !== idle_expect()) begin
                fails++;
                $display("FAIL reset_hold: T=%0d word=%h expected T=0 word=%h", t_out, dut_word, idle_expect());
            end
        end
        reset = 1'b0;
        #1;
        tests++;
        if (intf.IRWrite !== 1'b1 || intf.IRHighSel !== 1'b0 || intf.ARFRegSel !== 3'b100 || intf.ARFFunSel !== 2'b01) begin
            fails++;
            $display("FAIL reset_release_fetch: IRWrite=%b IRHighSel=%b ARFRegSel=%b ARFFunSel=%b expected 1 0 100 01",
                     intf.IRWrite, intf.IRHighSel, intf.ARFRegSel, intf.ARFFunSel);
        end
    endtask

    task automatic test_branch();
        run_instr(16'h0012, 4'b0000, -1);
        run_instr(16'h0412, 4'b1000, -1);
        run_instr(16'h0412, 4'b0000, -1);
    endtask

    task automatic test_inc_ld();
        run_instr(16'h0853, 4'b0000, -1);
        run_instr(16'h1900, 4'b0000, -1);
        run_instr(16'h0C4A, 4'b0101, -1);
        run_instr(16'h10D3, 4'b0000, -1);
        run_instr(16'h1623, 4'b0000, -1);
        run_instr(16'h1C00, 4'b0000, -1);
        run_instr(16'h0B13, 4'b0000, -1);
        run_instr(16'h1387, 4'b0000, -1);
        run_instr(16'hFC00, 4'b0000, -1);
    endtask

    task automatic test_reset_mid();
        run_instr(16'h0853, 4'b0000, 3);
        run_instr(16'h1900, 4'b0000, 2);
        run_instr(16'h0012, 4'b0000, 1);
        run_instr(16'h0853, 4'b0000, -1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ir;
        logic [3:0]  fl;
        int          abort_at;
        for (int i = 0; i < 300; i++) begin
            ir = 16'($urandom);
            if ($urandom_range(0, 3) != 0) ir[15:10] = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                ir[8] = 1'b0;
                ir[5] = 1'b0;
                ir[2] = 1'b0;
            end
            if (ir[15:10] == 6'd2 || ir[15:10] == 6'd3) ir[2] = 1'b0;
            fl       = 4'($urandom);
            abort_at = -1;
            if ($urandom_range(0, 7) == 0) abort_at = $urandom_range(0, 1 + exec_cycles(ir));
            run_instr(ir, fl, abort_at);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_branch();
        test_inc_ld();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
